// File: rtl/data_mem_mmio_pkg.sv
// data_mem_pkg: shared MMIO offsets, access size codes and FSM states for data_mem_mmio
package data_mem_pkg;
  localparam logic [2:0] OFF_DISPLAY = 3'd0;
  localparam logic [2:0] OFF_CYCLES = 3'd2;
  localparam logic [2:0] OFF_LEDS = 3'd4;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_HALF = 1'b1;
  typedef enum logic {INIT, IDLE} state_t;
endpackage

// File: rtl/data_mem_mmio_if.sv
// data_mem_mmio_if: MEM-stage request/response bus between core (master) and data memory (slave)
interface data_mem_mmio_if;
  logic req;
  logic write;
  logic size;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic ready;
  logic [15:0] rdata;
  logic rvalid;
  logic err;
  modport master (output req, write, size, addr, wdata, input ready, rdata, rvalid, err);
  modport slave (input req, write, size, addr, wdata, output ready, rdata, rvalid, err);
endinterface

// File: rtl/data_mem_mmio_ram.sv
// dmem_ram: MEM_BYTES x 8 RAM with hi/lo byte ports, per-port write enable and registered read
module dmem_ram #(
  parameter int MEM_BYTES = 256,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic          clk_pi,
  input  logic          reset_pi,
  input  logic          re,
  input  logic [AW-1:0] a_hi,
  input  logic [AW-1:0] a_lo,
  input  logic          we_hi,
  input  logic          we_lo,
  input  logic [7:0]    wd_hi,
  input  logic [7:0]    wd_lo,
  output logic [7:0]    rd_hi,
  output logic [7:0]    rd_lo
);
  logic [7:0] mem [MEM_BYTES];
  always_ff @(posedge clk_pi) begin
    if (we_hi) mem[a_hi] <= wd_hi;
    if (we_lo) mem[a_lo] <= wd_lo;
    if (reset_pi) begin
      rd_hi <= '0;
      rd_lo <= '0;
    end else if (re) begin
      rd_hi <= mem[a_hi];
      rd_lo <= mem[a_lo];
    end
  end
endmodule

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: big-endian byte/halfword data RAM with fill sweep and display/cycles/LED MMIO window
module data_mem_mmio
  import data_mem_pkg::*;
#(
  parameter int          MEM_BYTES = 256,
  parameter logic [7:0]  FILL_BYTE = 8'hFA,
  parameter logic [15:0] MMIO_BASE = 16'h9000,
  parameter logic [15:0] DISP_RST  = 16'hABAB
) (
  input  logic                   clk_pi,
  input  logic                   reset_pi,
  input  logic                   clk_en_pi,
  data_mem_mmio_if.slave         bus,
  output logic [15:0]            display_num_po,
  output logic [7:0]             leds_po
);
  localparam int AW = $clog2(MEM_BYTES);
  state_t state, state_n;
  logic [AW-1:0] ptr, a_hi, a_lo;
  logic [15:0] cycles, mmio_q, mmio_rd, off16;
  logic [2:0] off;
  logic [7:0] wd_hi, rd_hi, rd_lo;
  logic sel_ram, sel_byte, rvalid_q, err_q;
  logic acc, ld, st, in_ram, in_mmio, mmio_ok, bad, we_hi, we_lo, re;
  assign bus.ready = state == IDLE;
  assign acc = clk_en_pi & bus.req & bus.ready;
  assign ld = acc & !bus.write;
  assign st = acc & bus.write;
  assign in_ram = bus.addr < 16'(MEM_BYTES);
  assign off16 = bus.addr - MMIO_BASE;
  assign in_mmio = off16 < 16'd6;
  assign off = off16[2:0];
  assign mmio_ok = in_mmio & bus.size == SIZE_HALF & !off[0] & !(bus.write & off == OFF_CYCLES);
  assign bad = !in_ram & !mmio_ok;
  assign a_hi = state == INIT ? ptr : bus.addr[AW-1:0];
  assign a_lo = a_hi + 1'b1;
  assign we_hi = !reset_pi & clk_en_pi & (state == INIT | st & in_ram);
  assign we_lo = !reset_pi & st & in_ram & bus.size == SIZE_HALF;
  assign wd_hi = state == INIT ? FILL_BYTE : bus.size == SIZE_HALF ? bus.wdata[15:8] : bus.wdata[7:0];
  assign re = ld & in_ram;
  assign mmio_rd = !mmio_ok ? 16'h0 : off == OFF_DISPLAY ? display_num_po :
                   off == OFF_CYCLES ? cycles : {8'h00, leds_po};
  assign bus.rdata = sel_ram ? (sel_byte ? {8'h00, rd_hi} : {rd_hi, rd_lo}) : mmio_q;
  assign bus.rvalid = rvalid_q;
  assign bus.err = err_q;
  always_comb state_n = state == INIT && clk_en_pi && ptr == AW'(MEM_BYTES - 1) ? IDLE : state;
  always_ff @(posedge clk_pi) state <= reset_pi ? INIT : state_n;
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      ptr <= '0;
      cycles <= '0;
      display_num_po <= DISP_RST;
      leds_po <= '0;
      rvalid_q <= 1'b0;
      err_q <= 1'b0;
      mmio_q <= '0;
      sel_ram <= 1'b0;
      sel_byte <= 1'b0;
    end else if (clk_en_pi) begin
      if (state == INIT) ptr <= ptr + 1'b1;
      if (state == IDLE) cycles <= cycles + 16'd1;
      if (st & mmio_ok & off == OFF_DISPLAY) display_num_po <= bus.wdata;
      if (st & mmio_ok & off == OFF_LEDS) leds_po <= bus.wdata[7:0];
      rvalid_q <= ld;
      err_q <= acc & bad;
      if (ld) begin
        sel_ram <= in_ram;
        sel_byte <= bus.size == SIZE_BYTE;
        mmio_q <= mmio_rd;
      end
    end
  end
  dmem_ram #(.MEM_BYTES(MEM_BYTES)) u_ram (
    .clk_pi(clk_pi),
    .reset_pi(reset_pi),
    .re(re),
    .a_hi(a_hi),
    .a_lo(a_lo),
    .we_hi(we_hi),
    .we_lo(we_lo),
    .wd_hi(wd_hi),
    .wd_lo(bus.wdata[7:0]),
    .rd_hi(rd_hi),
    .rd_lo(rd_lo)
  );
endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio: directed and randomized checks of data_mem_mmio against a byte-array model
module tb_data_mem_mmio;
  logic clk_pi = 1'b0;
  logic reset_pi = 1'b1;
  logic clk_en_pi = 1'b1;
  logic [15:0] display_num_po;
  logic [7:0] leds_po;
  int checks = 0;
  int errors = 0;
  logic [7:0] m [256];
  data_mem_mmio_if bus ();
  data_mem_mmio dut (
    .clk_pi(clk_pi),
    .reset_pi(reset_pi),
    .clk_en_pi(clk_en_pi),
    .bus(bus),
    .display_num_po(display_num_po),
    .leds_po(leds_po)
  );
  always #5 clk_pi = ~clk_pi;
  task automatic tick();
    @(posedge clk_pi);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input logic w, input logic s, input logic [15:0] a, input logic [15:0] d);
    bus.req = 1'b1;
    bus.write = w;
    bus.size = s;
    bus.addr = a;
    bus.wdata = d;
    tick();
    bus.req = 1'b0;
  endtask
  // RAM/unmapped access checked against the byte-array model
  task automatic ram_op(input logic w, input logic s, input logic [15:0] a, input logic [15:0] d);
    logic [15:0] exp;
    logic mapped;
    mapped = a < 16'd256;
    exp = !mapped ? 16'h0 : s ? {m[a[7:0]], m[8'(a[7:0] + 8'd1)]} : {8'h00, m[a[7:0]]};
    xfer(w, s, a, d);
    chk("rnd_err", {31'b0, bus.err}, {31'b0, !mapped});
    chk("rnd_rvalid", {31'b0, bus.rvalid}, {31'b0, !w});
    if (!w) chk("rnd_rdata", {16'b0, bus.rdata}, {16'b0, exp});
    if (w && mapped) begin
      if (s) begin
        m[a[7:0]] = d[15:8];
        m[8'(a[7:0] + 8'd1)] = d[7:0];
      end else m[a[7:0]] = d[7:0];
    end
  endtask
  task automatic wait_ready(input string tag, input bit poke);
    int n;
    int stray;
    n = 0;
    stray = 0;
    do begin
      bus.req = poke;
      bus.write = 1'b0;
      bus.size = 1'b1;
      bus.addr = 16'h0000;
      tick();
      n++;
      if (bus.rvalid || bus.err) stray++;
    end while (!bus.ready && n < 1000);
    bus.req = 1'b0;
    chk({tag, "_sweep_len"}, n, 256);
    chk({tag, "_ignored_req"}, stray, 0);
  endtask
  initial begin
    logic [15:0] c1, c2, snap_rd, snap_disp;
    logic [7:0] snap_leds;
    logic snap_rv, snap_err, snap_rdy;
    bus.req = 1'b0;
    bus.write = 1'b0;
    bus.size = 1'b1;
    bus.addr = '0;
    bus.wdata = '0;
    tick();
    tick();
    chk("rst_ready", {31'b0, bus.ready}, 0);
    chk("rst_display", {16'b0, display_num_po}, 32'hABAB);
    chk("rst_leds", {24'b0, leds_po}, 0);
    chk("rst_rdata", {16'b0, bus.rdata}, 0);
    chk("rst_rvalid_err", {30'b0, bus.rvalid, bus.err}, 0);
    reset_pi = 1'b0;
    wait_ready("init", 1'b1);
    for (int i = 0; i < 256; i++) m[i] = 8'hFA;
    xfer(1'b0, 1'b1, 16'h0000, 16'h0);
    chk("fill_rvalid", {31'b0, bus.rvalid}, 1);
    chk("fill_rdata", {16'b0, bus.rdata}, 32'hFAFA);
    tick();
    chk("rvalid_drop", {31'b0, bus.rvalid}, 0);
    ram_op(1'b1, 1'b1, 16'h0010, 16'h1234);
    ram_op(1'b0, 1'b0, 16'h0011, 16'h0);
    chk("byte_ld", {16'b0, bus.rdata}, 32'h0034);
    ram_op(1'b0, 1'b1, 16'h0010, 16'h0);
    chk("half_ld", {16'b0, bus.rdata}, 32'h1234);
    ram_op(1'b1, 1'b1, 16'h00FF, 16'hBEEF);
    ram_op(1'b0, 1'b0, 16'h0000, 16'h0);
    chk("wrap_lo", {16'b0, bus.rdata}, 32'h00EF);
    ram_op(1'b0, 1'b1, 16'h00FF, 16'h0);
    chk("wrap_half", {16'b0, bus.rdata}, 32'hBEEF);
    xfer(1'b1, 1'b1, 16'h9000, 16'h0042);
    chk("disp_wr", {16'b0, display_num_po}, 32'h0042);
    chk("disp_wr_err", {31'b0, bus.err}, 0);
    ram_op(1'b0, 1'b1, 16'h0000, 16'h0);
    xfer(1'b0, 1'b1, 16'h9000, 16'h0);
    chk("disp_rd", {16'b0, bus.rdata}, 32'h0042);
    xfer(1'b0, 1'b1, 16'h9002, 16'h0);
    c1 = bus.rdata;
    xfer(1'b1, 1'b1, 16'h9002, 16'h5555);
    chk("cyc_store_err", {31'b0, bus.err}, 1);
    xfer(1'b0, 1'b1, 16'h9002, 16'h0);
    chk("cyc_store_nochange", {16'b0, 16'(bus.rdata - c1)}, 2);
    xfer(1'b0, 1'b0, 16'h9001, 16'h0);
    chk("mmio_byte_err", {31'b0, bus.err}, 1);
    chk("mmio_byte_rdata", {16'b0, bus.rdata}, 0);
    chk("mmio_byte_rvalid", {31'b0, bus.rvalid}, 1);
    xfer(1'b0, 1'b1, 16'h9003, 16'h0);
    chk("mmio_odd_err", {31'b0, bus.err}, 1);
    xfer(1'b1, 1'b0, 16'h9000, 16'h7777);
    chk("mmio_bytest_err", {31'b0, bus.err}, 1);
    chk("mmio_bytest_keep", {16'b0, display_num_po}, 32'h0042);
    xfer(1'b1, 1'b1, 16'h9004, 16'h5AA5);
    chk("leds_wr", {24'b0, leds_po}, 32'hA5);
    xfer(1'b0, 1'b1, 16'h9004, 16'h0);
    chk("leds_rd", {16'b0, bus.rdata}, 32'h00A5);
    xfer(1'b0, 1'b1, 16'h9002, 16'h0);
    c1 = bus.rdata;
    for (int i = 0; i < 9; i++) tick();
    xfer(1'b0, 1'b1, 16'h9002, 16'h0);
    c2 = bus.rdata;
    chk("cyc_diff", {16'b0, 16'(c2 - c1)}, 10);
    xfer(1'b0, 1'b1, 16'h9002, 16'h0);
    c1 = bus.rdata;
    tick();
    tick();
    snap_rd = bus.rdata;
    snap_rv = bus.rvalid;
    snap_err = bus.err;
    snap_rdy = bus.ready;
    snap_disp = display_num_po;
    snap_leds = leds_po;
    clk_en_pi = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.req = 1'b1;
      bus.write = 1'b1;
      bus.addr = 16'h9000;
      bus.wdata = 16'hDEAD;
      tick();
      chk("frozen", {bus.rdata, bus.rvalid, bus.err, bus.ready, leds_po, 5'b0},
          {snap_rd, snap_rv, snap_err, snap_rdy, snap_leds, 5'b0});
      chk("frozen_disp", {16'b0, display_num_po}, {16'b0, snap_disp});
    end
    bus.req = 1'b0;
    clk_en_pi = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    xfer(1'b0, 1'b1, 16'h9002, 16'h0);
    chk("cyc_diff_gated", {16'b0, 16'(bus.rdata - c1)}, 10);
    for (int i = 0; i < 150; i++) begin
      logic [15:0] a;
      a = $urandom_range(0, 9) == 0 ? ($urandom_range(0, 1) ? 16'h0300 : 16'hF000) : 16'($urandom_range(0, 255));
      ram_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
    end
    reset_pi = 1'b1;
    tick();
    reset_pi = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("mid_sweep_busy", {31'b0, bus.ready}, 0);
    reset_pi = 1'b1;
    tick();
    reset_pi = 1'b0;
    wait_ready("restart", 1'b0);
    for (int i = 0; i < 256; i++) m[i] = 8'hFA;
    chk("restart_display", {16'b0, display_num_po}, 32'hABAB);
    chk("restart_leds", {24'b0, leds_po}, 0);
    ram_op(1'b0, 1'b1, 16'h0300, 16'h0);
    ram_op(1'b0, 1'b1, 16'h00FF, 16'h0);
    ram_op(1'b0, 1'b1, 16'h0010, 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
